// File: rtl/pwm_fade_sequencer_pkg.sv
// Shared register map, control bit positions and sequencer states
// for the pwm fade sequencer.
package pwm_fade_sequencer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_LIMITS = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_fade_sequencer_step_timer.sv
// Step timer: reloads on load, counts down, ticks on the last
// cycle of the period (period 0 behaves as 1).
module step_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (period == '0) ? PERIOD_W'(1) : period;
    end else if (cnt != '0) begin
      cnt <= cnt - PERIOD_W'(1);
    end
  end

  assign tick = (cnt == PERIOD_W'(1)) && !load;

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Bus-mapped fade sequencer: ramps a duty value between limits and
// pushes each step into the pwm peripheral as a one-cycle write.
module pwm_fade_sequencer
  import pwm_fade_sequencer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wstrb,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        pwm_wstrb,
  output logic        pwm_sel,
  output logic [31:0] pwm_wdata,
  output logic        done
);

  state_t              state;
  logic                en;
  logic                mode;
  logic [PERIOD_W-1:0] period;
  logic [WIDTH-1:0]    min_d;
  logic [WIDTH-1:0]    max_d;
  logic [WIDTH-1:0]    duty;
  logic                dir;

  logic             wr;
  logic             ctrl_wr;
  logic             tick;
  logic [WIDTH-1:0] emax;
  logic             span;
  logic [WIDTH-1:0] nxt_duty;
  logic             nxt_dir;
  logic             at_end;

  assign wr      = sel && wstrb;
  assign ctrl_wr = wr && (addr == ADDR_CTRL);
  assign emax    = (max_d < min_d) ? min_d : max_d;
  assign span    = emax > min_d;
  assign pwm_sel = pwm_wstrb;

  step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == WRITE),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= 1'b0;
      mode   <= 1'b0;
      period <= '0;
      min_d  <= '0;
      max_d  <= '1;
    end else if (wr) begin
      case (addr)
        ADDR_CTRL: begin
          en   <= wdata[CTRL_EN];
          mode <= wdata[CTRL_MODE];
        end
        ADDR_PERIOD: period <= wdata[PERIOD_W-1:0];
        ADDR_LIMITS: begin
          min_d <= wdata[WIDTH-1:0];
          max_d <= wdata[8+:WIDTH];
        end
        default: ;
      endcase
    end
  end

  // Boundary checks keep the duty inside [min, emax] so it never wraps.
  always_comb begin
    nxt_duty = duty;
    nxt_dir  = dir;
    at_end   = 1'b0;
    if (dir) begin
      if (duty < emax) begin
        nxt_duty = duty + WIDTH'(1);
      end else if (!mode) begin
        at_end = 1'b1;
      end else begin
        nxt_dir = 1'b0;
        if (span) nxt_duty = duty - WIDTH'(1);
      end
    end else begin
      if (duty > min_d) begin
        nxt_duty = duty - WIDTH'(1);
      end else begin
        nxt_dir = 1'b1;
        if (span) nxt_duty = duty + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      duty      <= '0;
      dir       <= 1'b1;
      done      <= 1'b0;
      pwm_wstrb <= 1'b0;
      pwm_wdata <= '0;
    end else begin
      pwm_wstrb <= 1'b0;
      if (state != IDLE && !en) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (en) begin
            duty      <= min_d;
            dir       <= 1'b1;
            done      <= 1'b0;
            pwm_wstrb <= 1'b1;
            pwm_wdata <= {{(32-WIDTH){1'b0}}, min_d};
            state     <= WRITE;
          end
          WRITE: state <= WAIT;
          WAIT: if (tick) begin
            if (at_end) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              duty      <= nxt_duty;
              dir       <= nxt_dir;
              pwm_wstrb <= 1'b1;
              pwm_wdata <= {{(32-WIDTH){1'b0}}, nxt_duty};
              state     <= WRITE;
            end
          end
          DONE: if (ctrl_wr) state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel && !wstrb) begin
      case (addr)
        ADDR_CTRL: begin
          rdata[CTRL_EN]   = en;
          rdata[CTRL_MODE] = mode;
        end
        ADDR_PERIOD: rdata[PERIOD_W-1:0] = period;
        ADDR_LIMITS: begin
          rdata[WIDTH-1:0] = min_d;
          rdata[8+:WIDTH]  = max_d;
        end
        default: begin
          rdata[9]         = done;
          rdata[8]         = dir;
          rdata[WIDTH-1:0] = duty;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench: stimulus queues expected pwm writes and register
// reads; a negedge monitor pops and compares them.
module tb_pwm_fade_sequencer;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_PER  = 2'd1;
  localparam logic [1:0] A_LIM  = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wstrb = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        pwm_wstrb;
  logic        pwm_sel;
  logic [31:0] pwm_wdata;
  logic        done;

  pwm_fade_sequencer #(.WIDTH(4), .PERIOD_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .wstrb     (wstrb),
    .sel       (sel),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .pwm_wstrb (pwm_wstrb),
    .pwm_sel   (pwm_sel),
    .pwm_wdata (pwm_wdata),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          first;
    int          gap;
  } ex_t;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] exp;
    logic [31:0] mask;
  } rd_t;

  ex_t exp_q[$];
  rd_t rd_q[$];

  int cyc = 0;
  int mark_cyc = 0;
  int last_cyc = 0;
  int pops = 0;
  int issued = 0;
  int n_chk = 0;
  int n_fail = 0;
  int tmo_req = 0;
  int tmo_seen = 0;
  bit fin_req = 0;
  bit fin_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string aname(logic [1:0] a);
    case (a)
      2'd0: return "CTRL";
      2'd1: return "PERIOD";
      2'd2: return "LIMITS";
      default: return "STATUS";
    endcase
  endfunction

  always @(negedge clk) begin
    ex_t e;
    rd_t r;
    int  g;
    if (tmo_req != tmo_seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d waits expired, required 0", tmo_req);
      tmo_seen = tmo_req;
    end
    if (!rst && pwm_wstrb) begin
      n_chk++;
      if (pwm_sel !== 1'b1) begin
        n_fail++;
        $display("FAIL pwm_sel: got %b, expected 1", pwm_sel);
      end
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: wdata=%0d at cyc %0d, expected none",
                 pwm_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        if (pwm_wdata !== e.d) begin
          n_fail++;
          $display("FAIL pwm_wdata: got %0d, expected %0d", pwm_wdata, e.d);
        end
        g = cyc - (e.first ? mark_cyc : last_cyc);
        n_chk++;
        if (g != e.gap) begin
          n_fail++;
          $display("FAIL strobe_gap: got %0d cycles, expected %0d", g, e.gap);
        end
      end
      last_cyc = cyc;
      pops++;
    end
    if (sel && !wstrb && rd_q.size() != 0) begin
      r = rd_q.pop_front();
      n_chk++;
      if ((rdata & r.mask) !== (r.exp & r.mask)) begin
        n_fail++;
        $display("FAIL read_%s: got 0x%0h, expected 0x%0h (mask 0x%0h)",
                 aname(r.a), rdata & r.mask, r.exp & r.mask, r.mask);
      end
      if (r.a == A_STAT && r.mask[9]) begin
        n_chk++;
        if (done !== r.exp[9]) begin
          n_fail++;
          $display("FAIL done_port: got %b, expected %b", done, r.exp[9]);
        end
      end
    end
    if (fin_req && !fin_done) begin
      n_chk++;
      if (exp_q.size() != 0 || rd_q.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: %0d strobes %0d reads pending, expected 0",
                 exp_q.size(), rd_q.size());
      end
      fin_done = 1;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    sel = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; wstrb = 1'b0; wdata = '0;
    if (a == A_CTRL) mark_cyc = cyc;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e,
                    input logic [31:0] m);
    rd_t r;
    r.a = a; r.exp = e; r.mask = m;
    @(posedge clk);
    #1;
    rd_q.push_back(r);
    sel = 1'b1; wstrb = 1'b0; addr = a;
    @(negedge clk);
    #1;
    sel = 1'b0;
  endtask

  task automatic expect_w(input int v, input bit first, input int gap);
    ex_t e;
    e.d = 32'(v); e.first = first; e.gap = gap;
    exp_q.push_back(e);
    issued++;
  endtask

  task automatic wait_pops(input int target, input int budget);
    int t = 0;
    while (pops < target && t < budget) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (pops < target) tmo_req++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic int tri_val(int mn, int emx, int k);
    int l = emx - mn;
    int m;
    if (l == 0) return mn;
    m = k % (2 * l);
    return (m <= l) ? mn + m : mn + 2 * l - m;
  endfunction

  function automatic int tri_up(int mn, int emx, int k);
    int l = emx - mn;
    int m = k % (2 * l);
    return (k == 0 || (m >= 1 && m <= l)) ? 1 : 0;
  endfunction

  task automatic reset_reads();
    rd(A_CTRL, 32'h0, '1);
    rd(A_PER, 32'h0, '1);
    rd(A_LIM, 32'h0000_0F00, '1);
    rd(A_STAT, 32'h0000_0100, '1);
  endtask

  initial begin
    int mn, mx, emx, md, p, pe, n, v;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    reset_reads();
    idle(100);

    // one-shot 2..5, period 3
    wr(A_LIM, 32'h0000_0502);
    wr(A_PER, 32'd3);
    rd(A_PER, 32'd3, '1);
    rd(A_LIM, 32'h0000_0502, '1);
    for (int k = 0; k < 4; k++) expect_w(2 + k, k == 0, k == 0 ? 1 : 4);
    wr(A_CTRL, 32'h1);
    wait_pops(issued, 40);
    idle(10);
    rd(A_STAT, 32'h0000_0305, '1);
    rd(A_CTRL, 32'h1, '1);
    wr(A_CTRL, 32'h0);
    idle(3);
    rd(A_STAT, 32'h0000_0305, '1);

    // triangle 2..5 with dir checks, then disable at duty 4
    for (int k = 0; k < 9; k++)
      expect_w(tri_val(2, 5, k), k == 0, k == 0 ? 1 : 4);
    n = issued - 9;
    wr(A_CTRL, 32'h3);
    for (int k = 0; k < 9; k++) begin
      wait_pops(n + k + 1, 20);
      if (k == 3 || k == 4 || k == 6 || k == 7)
        rd(A_STAT, 32'((tri_up(2, 5, k) << 8) | tri_val(2, 5, k)), '1);
    end
    wr(A_CTRL, 32'h2);
    idle(30);
    rd(A_STAT, 32'h0000_0104, '1);

    // re-enable restarts at min
    expect_w(2, 1, 1);
    expect_w(3, 0, 4);
    wr(A_CTRL, 32'h3);
    wait_pops(issued, 20);
    wr(A_CTRL, 32'h2);
    idle(20);
    rd(A_STAT, 32'h0000_0103, '1);

    // max below min: emax = min, constant rewrites
    p = $urandom_range(2, 5);
    wr(A_LIM, 32'h0000_0307);
    wr(A_PER, 32'(p));
    for (int k = 0; k < 5; k++) expect_w(7, k == 0, k == 0 ? 1 : p + 1);
    wr(A_CTRL, 32'h3);
    wait_pops(issued, 6 * (p + 1) + 10);
    wr(A_CTRL, 32'h0);
    idle(20);
    rd(A_STAT, 32'h0000_0007, 32'h0000_02FF);

    // randomized ramps
    for (int it = 0; it < 10; it++) begin
      mn = $urandom_range(0, 15);
      mx = $urandom_range(0, 15);
      md = $urandom_range(0, 1);
      emx = (mx < mn) ? mn : mx;
      p = md ? $urandom_range(2, 6) : $urandom_range(0, 5);
      pe = (p == 0) ? 1 : p;
      wr(A_LIM, 32'((mx << 8) | mn));
      wr(A_PER, 32'(p));
      if (md == 0) begin
        n = emx - mn + 1;
        for (int k = 0; k < n; k++) expect_w(mn + k, k == 0, k == 0 ? 1 : pe + 1);
      end else begin
        n = $urandom_range(3, 12);
        for (int k = 0; k < n; k++)
          expect_w(tri_val(mn, emx, k), k == 0, k == 0 ? 1 : pe + 1);
      end
      wr(A_CTRL, 32'(md * 2 + 1));
      wait_pops(issued, n * (pe + 1) + 20);
      if (md == 0) begin
        idle(pe + 5);
        rd(A_STAT, 32'(32'h300 | emx), '1);
        wr(A_CTRL, 32'h0);
      end else begin
        wr(A_CTRL, 32'h2);
        idle(2 * pe + 6);
        v = tri_val(mn, emx, n - 1);
        rd(A_STAT, 32'(v), 32'h0000_020F);
      end
      idle(5);
    end

    // reset landing in a WRITE cycle
    wr(A_LIM, 32'h0000_0502);
    wr(A_PER, 32'd3);
    expect_w(2, 1, 1);
    wr(A_CTRL, 32'h1);
    wait_pops(issued, 10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(20);
    reset_reads();

    fin_req = 1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
